// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the four requesters, the arbiter and the SDRAM controller.
// slave  : arbiter view (requests and controller status in, grants and commands out).
// master : environment view (requesters plus controller), the mirror image.
interface sdram_arbiter_if;
  // Requester side
  logic [3:0]  REQ;
  logic [3:0]  WE;
  logic [25:0] ADDR0;
  logic [25:0] ADDR1;
  logic [25:0] ADDR2;
  logic [25:0] ADDR3;
  logic [15:0] DIN0;
  logic [15:0] DIN1;
  logic [15:0] DIN2;
  logic [15:0] DIN3;
  logic [1:0]  BS0;
  logic [1:0]  BS1;
  logic [1:0]  BS2;
  logic [1:0]  BS3;
  logic [3:0]  ACK;
  logic [3:0]  DONE;
  logic [15:0] RDATA;
  logic        RFSH_TICK;

  // Controller side
  logic        SDRAM_RD;
  logic        SDRAM_WR;
  logic [25:0] SDRAM_ADDR;
  logic [15:0] SDRAM_DIN;
  logic [1:0]  SDRAM_BS;
  logic        SDRAM_RFSH;
  logic        SDRAM_READY;
  logic [15:0] SDRAM_DOUT;

  modport slave (
    input  REQ, WE, ADDR0, ADDR1, ADDR2, ADDR3, DIN0, DIN1, DIN2, DIN3,
    input  BS0, BS1, BS2, BS3, RFSH_TICK, SDRAM_READY, SDRAM_DOUT,
    output ACK, DONE, RDATA, SDRAM_RD, SDRAM_WR, SDRAM_ADDR, SDRAM_DIN, SDRAM_BS, SDRAM_RFSH
  );

  modport master (
    output REQ, WE, ADDR0, ADDR1, ADDR2, ADDR3, DIN0, DIN1, DIN2, DIN3,
    output BS0, BS1, BS2, BS3, RFSH_TICK, SDRAM_READY, SDRAM_DOUT,
    input  ACK, DONE, RDATA, SDRAM_RD, SDRAM_WR, SDRAM_ADDR, SDRAM_DIN, SDRAM_BS, SDRAM_RFSH
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Four-port request/acknowledge arbiter and command sequencer for the single-port
// SDRAM controller. Port 0 = M68K/CD read, 1 = CROM, 2 = SROM, 3 = CD write.
// Fixed priority 0 > 1 > 2 > 3, refresh scheduled as a saturating debt that forces
// itself ahead of all ports once it reaches RFSH_FORCE.
// Optional build macro SDRAM_ARB_AGING_EN: ports 1..3 count lost rounds and are
// promoted above all non-aged ports once the count reaches AGE_LIMIT.
// All outputs are registered; reset is synchronous and active-low.
module sdram_arbiter #(
  parameter int unsigned AGE_LIMIT  = 7,
  parameter int unsigned RFSH_FORCE = 4
) (
  input logic            CLK,
  input logic            nRESET,
  sdram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCmd, StBusy, StFin} state_e;

  state_e      state_q;
  logic [1:0]  port_q;
  logic        is_wr_q;
  logic [2:0]  debt_q;
  logic [2:0]  debt_d;
  logic        rd_q;
  logic        wr_q;
  logic [25:0] addr_q;
  logic [15:0] din_q;
  logic [1:0]  bs_q;
  logic        rfsh_q;
  logic [3:0]  ack_q;
  logic [3:0]  done_q;
  logic [15:0] rdata_q;

  logic        win_vld;
  logic [1:0]  win_id;
  logic        force_rfsh;
  logic        rfsh_issue;
  logic        grant;

  logic [25:0] sel_addr;
  logic [15:0] sel_din;
  logic [1:0]  sel_bs;
  logic        sel_we;

`ifdef SDRAM_ARB_AGING_EN
  logic [2:0]  age_q [1:3];
`endif

  // Winner selection: fixed priority, optionally overridden by aged ports.
  always_comb begin
    win_vld = |bus.REQ;
    win_id  = 2'd0;
    // Scan downwards so the lowest requesting index is left standing.
    for (int i = 3; i >= 0; i--) begin
      if (bus.REQ[i]) begin
        win_id = 2'(i);
      end
    end
`ifdef SDRAM_ARB_AGING_EN
    // Aged ports outrank every non-aged port; lowest aged index wins.
    for (int i = 3; i >= 1; i--) begin
      if (bus.REQ[i] && (32'(age_q[i]) >= AGE_LIMIT)) begin
        win_id = 2'(i);
      end
    end
`endif
  end

  // Command fields of the selected port; reads always use both byte lanes.
  always_comb begin
    sel_addr = bus.ADDR0;
    sel_din  = bus.DIN0;
    sel_bs   = bus.BS0;
    unique case (win_id)
      2'd0: begin
        sel_addr = bus.ADDR0;
        sel_din  = bus.DIN0;
        sel_bs   = bus.BS0;
      end
      2'd1: begin
        sel_addr = bus.ADDR1;
        sel_din  = bus.DIN1;
        sel_bs   = bus.BS1;
      end
      2'd2: begin
        sel_addr = bus.ADDR2;
        sel_din  = bus.DIN2;
        sel_bs   = bus.BS2;
      end
      2'd3: begin
        sel_addr = bus.ADDR3;
        sel_din  = bus.DIN3;
        sel_bs   = bus.BS3;
      end
      default: begin
        sel_addr = bus.ADDR0;
        sel_din  = bus.DIN0;
        sel_bs   = bus.BS0;
      end
    endcase
    sel_we = bus.WE[win_id];
    if (!sel_we) begin
      sel_bs = 2'b11;
    end
  end

  // IDLE decision: forced refresh, then a port grant, then opportunistic refresh.
  always_comb begin
    force_rfsh = 32'(debt_q) >= RFSH_FORCE;
    rfsh_issue = 1'b0;
    grant      = 1'b0;
    if (state_q == StIdle && bus.SDRAM_READY) begin
      if (force_rfsh) begin
        rfsh_issue = 1'b1;
      end else if (win_vld) begin
        grant = 1'b1;
      end else if (debt_q != 3'd0) begin
        rfsh_issue = 1'b1;
      end
    end
  end

  // Refresh debt: tick and issue in the same cycle cancel; a tick at 7 is dropped.
  always_comb begin
    debt_d = debt_q;
    if (bus.RFSH_TICK && !rfsh_issue) begin
      if (debt_q != 3'd7) begin
        debt_d = debt_q + 3'd1;
      end
    end else if (!bus.RFSH_TICK && rfsh_issue) begin
      debt_d = debt_q - 3'd1;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state_q <= StIdle;
      port_q  <= 2'd0;
      is_wr_q <= 1'b0;
      debt_q  <= 3'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 26'd0;
      din_q   <= 16'd0;
      bs_q    <= 2'b11;
      ack_q   <= 4'd0;
      done_q  <= 4'd0;
      rdata_q <= 16'd0;
      // rfsh_q deliberately keeps its level: a reset must not look like a refresh edge.
    end else begin
      ack_q  <= 4'd0;
      done_q <= 4'd0;
      debt_q <= debt_d;
      unique case (state_q)
        StIdle: begin
          if (rfsh_issue) begin
            rfsh_q <= ~rfsh_q;
          end else if (grant) begin
            port_q  <= win_id;
            is_wr_q <= sel_we;
            addr_q  <= sel_addr;
            din_q   <= sel_din;
            bs_q    <= sel_bs;
            rd_q    <= ~sel_we;
            wr_q    <= sel_we;
            ack_q   <= 4'b0001 << win_id;
            state_q <= StCmd;
          end
        end
        StCmd: begin
          // Controller accepted the command once it drops READY.
          if (!bus.SDRAM_READY) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (bus.SDRAM_READY) begin
            if (!is_wr_q) begin
              rdata_q <= bus.SDRAM_DOUT;
            end
            done_q  <= 4'b0001 << port_q;
            state_q <= StFin;
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef SDRAM_ARB_AGING_EN
  // Lost-round counters: count while requesting and beaten, clear when granted.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      for (int i = 1; i <= 3; i++) begin
        age_q[i] <= 3'd0;
      end
    end else if (grant) begin
      for (int i = 1; i <= 3; i++) begin
        if (win_id == 2'(i)) begin
          age_q[i] <= 3'd0;
        end else if (bus.REQ[i] && age_q[i] != 3'd7) begin
          age_q[i] <= age_q[i] + 3'd1;
        end
      end
    end
  end
`else
  // Limit is only meaningful when aging is built in.
  logic unused_age_limit;
  assign unused_age_limit = ^AGE_LIMIT;
`endif

  assign bus.ACK        = ack_q;
  assign bus.DONE       = done_q;
  assign bus.RDATA      = rdata_q;
  assign bus.SDRAM_RD   = rd_q;
  assign bus.SDRAM_WR   = wr_q;
  assign bus.SDRAM_ADDR = addr_q;
  assign bus.SDRAM_DIN  = din_q;
  assign bus.SDRAM_BS   = bs_q;
  assign bus.SDRAM_RFSH = rfsh_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a behavioural SDRAM controller and a
// grant/done scoreboard.
module tb_sdram_arbiter;

  logic CLK    = 1'b0;
  logic nRESET = 1'b0;

  sdram_arbiter_if bus ();

  sdram_arbiter dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          port;
    logic        wr;
    logic [25:0] addr;
    logic [15:0] din;
    logic [1:0]  bs;
  } exp_t;

  exp_t grant_q[$];
  exp_t exp_done_q[$];

  int n_checks  = 0;
  int n_pass    = 0;
  int n_fail    = 0;
  int rfsh_cnt  = 0;
  int done_seen = 0;
  int cyc       = 0;
  int last_ack  = -100;
  int lat       = 5;
  logic        rfsh_prev = 1'b0;
  logic [15:0] last_rd   = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_val(input logic [25:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    return (a == 26'h0040010) ? 16'hBEEF : (lo ^ 16'h5A5A);
  endfunction

  function automatic exp_t mk(input int p);
    exp_t e;
    e.port = p;
    e.wr   = bus.WE[p];
    case (p)
      0:       begin e.addr = bus.ADDR0; e.din = bus.DIN0; e.bs = bus.BS0; end
      1:       begin e.addr = bus.ADDR1; e.din = bus.DIN1; e.bs = bus.BS1; end
      2:       begin e.addr = bus.ADDR2; e.din = bus.DIN2; e.bs = bus.BS2; end
      default: begin e.addr = bus.ADDR3; e.din = bus.DIN3; e.bs = bus.BS3; end
    endcase
    if (!e.wr) e.bs = 2'b11;
    return e;
  endfunction

  // Behavioural controller: drops READY one edge after a strobe, raises it with data lat edges later.
  logic        m_ready = 1'b1;
  logic [15:0] m_dout  = 16'd0;
  logic [15:0] m_data  = 16'd0;
  logic        m_busy  = 1'b0;
  int          m_cnt   = 0;
  assign bus.SDRAM_READY = m_ready;
  assign bus.SDRAM_DOUT  = m_dout;

  always @(posedge CLK) begin
    cyc++;
    if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy  = 1'b0;
        m_ready <= 1'b1;
        m_dout  <= m_data;
      end
    end else if (bus.SDRAM_RD || bus.SDRAM_WR) begin
      m_busy  = 1'b1;
      m_cnt   = lat;
      m_data  = mem_val(bus.SDRAM_ADDR);
      m_ready <= 1'b0;
    end
  end

  // Monitor: grant order, command fields, completion order, read data, refresh toggles.
  always @(negedge CLK) begin
    exp_t e;
    if (!nRESET) begin
      exp_done_q.delete();
      last_rd = 16'd0;
    end else begin
      if (bus.ACK != 4'd0) begin
        if (grant_q.size() == 0) begin
          chk("ack_unexpected", 32'(bus.ACK), 32'd0);
        end else begin
          e = grant_q.pop_front();
          chk("ack_port", 32'(bus.ACK), 32'(1) << e.port);
          chk("ack_gap_ge3", 32'((cyc - last_ack) >= 3), 32'd1);
          last_ack = cyc;
          chk("cmd_rd", 32'(bus.SDRAM_RD), 32'(!e.wr));
          chk("cmd_wr", 32'(bus.SDRAM_WR), 32'(e.wr));
          chk("cmd_addr", 32'(bus.SDRAM_ADDR), 32'(e.addr));
          chk("cmd_din", 32'(bus.SDRAM_DIN), 32'(e.din));
          chk("cmd_bs", 32'(bus.SDRAM_BS), 32'(e.bs));
          exp_done_q.push_back(e);
        end
      end
      if (bus.DONE != 4'd0) begin
        done_seen++;
        if (exp_done_q.size() == 0) begin
          chk("done_unexpected", 32'(bus.DONE), 32'd0);
        end else begin
          e = exp_done_q.pop_front();
          chk("done_port", 32'(bus.DONE), 32'(1) << e.port);
          if (!e.wr) begin
            chk("rdata", 32'(bus.RDATA), 32'(mem_val(e.addr)));
            last_rd = mem_val(e.addr);
          end else begin
            chk("rdata_hold_on_write", 32'(bus.RDATA), 32'(last_rd));
          end
        end
      end
    end
    if (bus.SDRAM_RFSH !== rfsh_prev) rfsh_cnt++;
    rfsh_prev = bus.SDRAM_RFSH;
  end

  task automatic wait_ack(input int p, input int max);
    for (int c = 0; c < max; c++) begin
      @(negedge CLK);
      if (bus.ACK[p]) begin
        bus.REQ[p] = 1'b0;
        return;
      end
    end
    chk("ack_timeout", 32'(bus.ACK), 32'(1) << p);
  endtask

  task automatic wait_done(input int p, input int max);
    for (int c = 0; c < max; c++) begin
      @(negedge CLK);
      if (bus.DONE[p]) return;
    end
    chk("done_timeout", 32'(bus.DONE), 32'(1) << p);
  endtask

  // Requesters drop REQ on ACK; port 0 re-requests on each DONE while p0_more lasts.
  task automatic run(input int max, input int p0_more);
    int left;
    left = p0_more;
    for (int c = 0; c < max; c++) begin
      @(negedge CLK);
      bus.REQ = bus.REQ & ~bus.ACK;
      if (bus.DONE[0] && left > 0) begin
        bus.REQ[0] = 1'b1;
        left--;
      end
      if (bus.REQ == 4'd0 && left == 0 && grant_q.size() == 0 && exp_done_q.size() == 0) return;
    end
    chk("run_timeout", 32'(grant_q.size() + exp_done_q.size()), 32'd0);
  endtask

  task automatic ticks(input int n);
    bus.RFSH_TICK = 1'b1;
    repeat (n) @(negedge CLK);
    bus.RFSH_TICK = 1'b0;
  endtask

  initial begin
    int n;
    int r0;
    int d0;
    logic rf;
    bus.REQ = 4'd0;       bus.WE = 4'd0;        bus.RFSH_TICK = 1'b0;
    bus.ADDR0 = 26'd0;    bus.ADDR1 = 26'd0;    bus.ADDR2 = 26'd0;    bus.ADDR3 = 26'd0;
    bus.DIN0 = 16'h0A0A;  bus.DIN1 = 16'h1B1B;  bus.DIN2 = 16'h2C2C;  bus.DIN3 = 16'h3D3D;
    bus.BS0 = 2'b11;      bus.BS1 = 2'b11;      bus.BS2 = 2'b11;      bus.BS3 = 2'b01;

    // Reset values
    repeat (3) @(negedge CLK);
    chk("rst_rd", 32'(bus.SDRAM_RD), 32'd0);
    chk("rst_wr", 32'(bus.SDRAM_WR), 32'd0);
    chk("rst_addr", 32'(bus.SDRAM_ADDR), 32'd0);
    chk("rst_din", 32'(bus.SDRAM_DIN), 32'd0);
    chk("rst_bs", 32'(bus.SDRAM_BS), 32'h3);
    chk("rst_rfsh", 32'(bus.SDRAM_RFSH), 32'd0);
    chk("rst_ack", 32'(bus.ACK), 32'd0);
    chk("rst_done", 32'(bus.DONE), 32'd0);
    chk("rst_rdata", 32'(bus.RDATA), 32'd0);
    nRESET = 1'b1;
    @(negedge CLK);

    // Single read on port 2, controller latency 5
    lat = 5;
    bus.ADDR2 = 26'h0040010;
    grant_q.push_back(mk(2));
    bus.REQ = 4'b0100;
    @(negedge CLK);
    chk("ack_latency", 32'(bus.ACK), 32'h4);
    bus.REQ[2] = 1'b0;
    n = 0;
    for (int c = 0; c < 30 && !bus.DONE[2]; c++) begin
      @(negedge CLK);
      n++;
    end
    chk("ack_to_done", n, lat + 2);
    repeat (3) @(negedge CLK);

    // Contention: all four together, port 3 writes with BS3=01
    bus.ADDR0 = 26'h0000100; bus.ADDR1 = 26'h0000201;
    bus.ADDR2 = 26'h0000302; bus.ADDR3 = 26'h2000403;
    bus.WE = 4'b1000;
    for (int p = 0; p < 4; p++) grant_q.push_back(mk(p));
    bus.REQ = 4'b1111;
    run(200, 0);
    repeat (3) @(negedge CLK);

    // Port 0 hammers while port 3 waits
    lat = 3;
    bus.ADDR3 = 26'h3000000; bus.DIN3 = 16'h7E57; bus.BS3 = 2'b10;
`ifdef SDRAM_ARB_AGING_EN
    for (int k = 0; k < 7; k++) grant_q.push_back(mk(0));
    grant_q.push_back(mk(3));
    grant_q.push_back(mk(0));
`else
    for (int k = 0; k < 8; k++) grant_q.push_back(mk(0));
    grant_q.push_back(mk(3));
`endif
    bus.REQ = 4'b1001;
    run(300, 7);
    repeat (3) @(negedge CLK);

    // Refresh debt of 4 built while port 1 is busy: one forced refresh, then the grant
    lat = 10;
    bus.WE = 4'b0000;
    bus.ADDR1 = 26'h0000100;
    grant_q.push_back(mk(1));
    bus.REQ[1] = 1'b1;
    wait_ack(1, 20);
    ticks(4);
    r0 = rfsh_cnt;
    wait_done(1, 30);
    grant_q.push_back(mk(1));
    bus.REQ[1] = 1'b1;
    wait_ack(1, 20);
    chk("rfsh_before_ack_debt4", rfsh_cnt - r0, 1);
    wait_done(1, 30);
    repeat (8) @(negedge CLK);
    chk("rfsh_drain_debt4", rfsh_cnt - r0, 4);

    // Eight ticks saturate at 7: four forced refreshes before the grant, seven in total
    grant_q.push_back(mk(1));
    bus.REQ[1] = 1'b1;
    wait_ack(1, 20);
    ticks(8);
    r0 = rfsh_cnt;
    wait_done(1, 30);
    grant_q.push_back(mk(1));
    bus.REQ[1] = 1'b1;
    wait_ack(1, 20);
    chk("rfsh_before_ack_debt7", rfsh_cnt - r0, 4);
    wait_done(1, 30);
    repeat (10) @(negedge CLK);
    chk("rfsh_drain_debt7", rfsh_cnt - r0, 7);

    // Idle single tick gives one toggle
    r0 = rfsh_cnt;
    ticks(1);
    repeat (5) @(negedge CLK);
    chk("rfsh_idle_single", rfsh_cnt - r0, 1);

    // Reset during BUSY
    bus.ADDR0 = 26'h1234567;
    grant_q.push_back(mk(0));
    bus.REQ[0] = 1'b1;
    wait_ack(0, 20);
    repeat (3) @(negedge CLK);
    rf = bus.SDRAM_RFSH;
    d0 = done_seen;
    nRESET = 1'b0;
    @(negedge CLK);
    chk("midrst_rd", 32'(bus.SDRAM_RD), 32'd0);
    chk("midrst_addr", 32'(bus.SDRAM_ADDR), 32'd0);
    chk("midrst_bs", 32'(bus.SDRAM_BS), 32'h3);
    chk("midrst_done", 32'(bus.DONE), 32'd0);
    chk("midrst_rdata", 32'(bus.RDATA), 32'd0);
    chk("midrst_rfsh_hold", 32'(bus.SDRAM_RFSH), 32'(rf));
    repeat (2) @(negedge CLK);
    nRESET = 1'b1;
    repeat (15) @(negedge CLK);
    chk("no_done_after_reset", done_seen - d0, 0);
    bus.WE = 4'b1000;
    grant_q.push_back(mk(3));
    bus.REQ[3] = 1'b1;
    wait_ack(3, 30);
    wait_done(3, 30);
    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", 32'(grant_q.size() + exp_done_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
